// File: rtl/baud_pkg.sv
// Shared defaults and helpers for the programmable baud generator.
// The defaults give 19200 baud at 16x oversampling from a 50 MHz clock.
package baud_pkg;

    localparam int unsigned DIV_RESET_DEF = 163;
    localparam int unsigned OVS_DEF       = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_m_counter.sv
// Modulo-m counter with enable, synchronous clear and a runtime modulus.
// The wrap flag is high on the enabled cycle that returns the count to zero.
module mod_m_counter #(
    parameter int unsigned W  = 8,
    parameter int unsigned MW = W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    input  logic [MW-1:0] m,
    output logic [W-1:0]  q,
    output logic          wrap
);

    logic [MW-1:0] last;

    assign last = m - MW'(1);

    // A modulus shrunk below the held count wraps at once instead of
    // running through the whole counter range.
    assign wrap = en && (MW'(q) >= last);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (en) begin
            q <= wrap ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/baud_gen_prog.sv
// Runtime-programmable baud generator: sample tick every div_cur clocks,
// bit tick every OVS sample ticks, glitch-free divisor update via valid/ready.
module baud_gen_prog
    import baud_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned DIV_RESET = DIV_RESET_DEF,
    parameter int unsigned OVS       = OVS_DEF,
    parameter int unsigned OW        = clog2(OVS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          resync,
    input  logic          div_valid,
    input  logic [N-1:0]  div_in,
    output logic          div_ready,
    output logic          s_tick,
    output logic          b_tick,
    output logic [N-1:0]  q,
    output logic [OW-1:0] os_q,
    output logic [N-1:0]  div_cur
);

    localparam int unsigned OSW = OW + 1;

    slot_t          slot;
    logic [N-1:0]   pend;
    logic [N-1:0]   div_eff;
    logic [OSW-1:0] os_mod;
    logic           s_wrap;
    logic           os_wrap;
    logic           apply;

    assign os_mod    = OSW'(OVS);
    assign div_eff   = (div_in == '0) ? N'(1) : div_in;
    assign div_ready = (slot == SLOT_EMPTY);
    assign s_tick    = s_wrap && !reset;
    assign b_tick    = os_wrap;

    // Swap only where the running period cannot be cut short: at its wrap,
    // while counting is stalled, or when the counters are being cleared.
    assign apply = (slot == SLOT_FULL) && (s_tick || !en || resync);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cur <= N'(DIV_RESET);
            pend    <= '0;
            slot    <= SLOT_EMPTY;
        end else if (apply) begin
            div_cur <= pend;
            slot    <= SLOT_EMPTY;
        end else if (div_valid && slot == SLOT_EMPTY) begin
            pend <= div_eff;
            slot <= SLOT_FULL;
        end
    end

    mod_m_counter #(
        .W  (N),
        .MW (N)
    ) u_sample (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (resync),
        .m     (div_cur),
        .q     (q),
        .wrap  (s_wrap)
    );

    mod_m_counter #(
        .W  (OW),
        .MW (OSW)
    ) u_oversample (
        .clk   (clk),
        .reset (reset),
        .en    (s_tick),
        .clr   (resync),
        .m     (os_mod),
        .q     (os_q),
        .wrap  (os_wrap)
    );

endmodule

// File: doc/baud_gen_prog.md
# baud_gen_prog

Runtime-programmable baud-rate generator with 16x oversampling, the parametrised successor of the fixed-modulus baud generator used by the UART link to the pipeline debug unit. It produces a sample tick every `div_cur` clocks and a bit tick every `OVS` sample ticks. It accepts a new divisor through a valid/ready handshake without glitching the running period. It also supports realignment (`resync`) for receiver start-bit detection.

## Interface
- `N`, 8: width of the divisor and of the sample counter.
- `DIV_RESET`, 163: divisor loaded at reset (50 MHz / (19200 × 16)); legal range 1..2^N−1.
- `OVS`, 16: sample ticks per bit tick; must be ≥ 2.
- `OW`, $clog2(OVS): width of the oversample index.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `en` in 1: count enable; when low, all counters hold.
- `resync` in 1: clears both counters to 0 at the next edge.
- `div_valid` in 1: new-divisor request.
- `div_in` in N: new divisor value.
- `div_ready` out 1: high when a new divisor can be accepted.
- `s_tick` out 1: sample tick, 1 cycle wide.
- `b_tick` out 1: bit tick, 1 cycle wide, coincident with an `s_tick`.
- `q` out N: sample counter value.
- `os_q` out OW: oversample index.
- `div_cur` out N: divisor currently in effect.

## Operation
- **Reset values.**
  - `q` = 0, `os_q` = 0, `div_cur` = DIV_RESET.
  - Pending slot empty; `div_ready` = 1.
  - `s_tick` and `b_tick` are forced to 0 while `reset` is high.
- **Effective divisor.** Written value 0 is stored as 1. An effective divisor of 1 gives `s_tick` every enabled cycle.
- **Sample counter.**
  - Counts 0..`div_cur`−1 on each enabled edge, then wraps to 0.
  - `s_tick` = `en` && `q` == `div_cur`−1, combinational from registered state.
- **Oversample counter.**
  - Advances on each edge where `s_tick` = 1; wraps from OVS−1 to 0.
  - `b_tick` = `s_tick` && `os_q` == OVS−1.
- **Divisor handshake.**
  - A transfer occurs at an edge where `div_valid` && `div_ready`; the value is captured into the pending slot.
  - `div_ready` is 0 from the next cycle until the pending value is applied.
  - A pending value is applied at the first later edge that satisfies any of:
    - `s_tick` = 1 (the counter wraps to 0 in the same edge);
    - `en` = 0;
    - `resync` = 1.
  - On apply: `div_cur` ← pending, and `div_ready` = 1 in the following cycle.
  - Only one pending slot exists; requests made while `div_ready` = 0 are not accepted.
- **Resync.**
  - Sets `q` = 0 and `os_q` = 0 regardless of `en`.
  - Outputs in the resync cycle itself still decode the pre-clear state.
- **Priority:** reset > resync > divisor apply > count.
- **Reset mid-operation:** any pending divisor is discarded.

## Timing
- **First tick.** With `en` held high from reset release at edge 0, the first `s_tick` is high during cycle DIV_RESET−1. It repeats every `div_cur` cycles.
- **First bit tick.** The first `b_tick` is high in cycle OVS×DIV_RESET−1; its period is OVS×`div_cur` cycles.
- **Divisor change.** The old period always completes in full. The first full period at the new divisor begins at the wrap edge.
- **`div_ready`.** Minimum low time is 1 cycle (request accepted while `en` = 0). Maximum low time is `div_cur` enabled cycles.
- **Hold behaviour.** With `en` low, `q` and `os_q` hold and both ticks are 0. No cycles are lost when `en` is re-raised.

## Structure
- Shared package `baud_pkg`: DIV_RESET default, OVS default, and a `clog2` constant function.
- Sub-module `mod_m_counter`: holds the counter with enable, sync clear, runtime modulus input, and wrap flag. It is instantiated twice:
  - sample counter, with modulus = `div_cur`;
  - oversample counter, with modulus = OVS and enable = `s_tick`.
- Divisor handshake and pending register live in the top level.

## Test plan
- **Reset defaults, free run.** `reset` for 3 cycles, then `en` = 1. Expect `div_cur` = 163, `div_ready` = 1, `s_tick` at cycles 162, 325, 488, and `b_tick` first at cycle 2607.
- **Divisor change mid-period.** Write `div_in` = 10 at `q` = 50. Expect `div_ready` = 0, the current 163-cycle period completes, `div_cur` = 10 after the wrap, subsequent `s_tick` every 10 cycles, and `div_ready` back to 1.
- **Zero divisor.** Write `div_in` = 0 with `en` = 0. Expect it applied on the next edge, `div_cur` = 1, and `s_tick` high every cycle once `en` = 1.
- **Enable low.** Drop `en` at `q` = 40, `os_q` = 5 for 20 cycles. Expect `q`/`os_q` frozen, no ticks, and the next `s_tick` 122 cycles after re-enable.
- **Resync.** Pulse `resync` at `q` = 100, `os_q` = 7 while a divisor of 20 is pending. Expect `q` = 0, `os_q` = 0, `div_cur` = 20 after that edge, and the next `s_tick` 20 cycles later.
- **Reset mid-operation.** Assert `reset` with a divisor pending and `q` = 90. Expect all outputs back at their reset values, the pending value dropped, and `div_cur` = 163.
